// File: rtl/joybus_poll_master.sv
// Joybus (GameCube controller) bus master: serialises a command onto the
// open-drain data line, sends the stop bit, then captures the controller reply.
module joybus_poll_master #(
    parameter int CLK_PER_US = 100,
    parameter int CMD_BITS   = 24,
    parameter int RSP_BITS   = 64,
    parameter int TIMEOUT_US = 200,
    localparam int CLW = $clog2(CMD_BITS + 1),
    localparam int RLW = $clog2(RSP_BITS + 1)
) (
    input  logic                clk100mhz,
    input  logic                reset,
    input  logic                start,
    input  logic [CMD_BITS-1:0] cmd,
    input  logic [CLW-1:0]      cmd_len,
    input  logic [RLW-1:0]      rsp_len,
    input  logic                data_in,
    output logic                data_oe,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [RSP_BITS-1:0] rsp
);
    localparam int UW = $clog2(CLK_PER_US);
    localparam int EW = $clog2((TIMEOUT_US > 4 ? TIMEOUT_US : 4) + 1);

    typedef enum logic [2:0] {
        IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_SAMPLE, RX_HIGH, FINISH
    } state_t;

    state_t state, state_nxt;

    logic [UW-1:0]       us_cnt;
    logic [EW-1:0]       us_el;
    logic                us_tick;
    logic                cell_end;
    logic                to_expired;
    logic                sample_now;
    logic                set_to;

    logic                sync_meta, sync, sync_prev, fall;

    logic [CLW-1:0]      cmd_len_c, tx_left;
    logic [CMD_BITS-1:0] tx_sh, tx_init;
    logic [RLW-1:0]      rsp_len_c, rx_len, rx_cnt;
    logic [RSP_BITS-1:0] rx_sh;
    logic                timeout_r;

    assign cmd_len_c = (cmd_len > CLW'(CMD_BITS)) ? CLW'(CMD_BITS) : cmd_len;
    assign rsp_len_c = (rsp_len > RLW'(RSP_BITS)) ? RLW'(RSP_BITS) : rsp_len;
    // Left-align the command so the next bit to send is always the MSB.
    assign tx_init   = cmd << (CLW'(CMD_BITS) - cmd_len_c);

    assign us_tick    = (us_cnt == UW'(CLK_PER_US - 1));
    assign cell_end   = (state == TX_BIT) && us_tick && (us_el == EW'(3));
    assign to_expired = us_tick && (us_el == EW'(TIMEOUT_US - 1));
    assign sample_now = us_tick && (us_el == EW'(1));
    assign fall       = sync_prev & ~sync;

    always_ff @(posedge clk100mhz) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        set_to    = 1'b0;
        data_oe   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (cmd_len_c == '0) ? TX_STOP : TX_BIT;
            end
            TX_BIT: begin
                data_oe = tx_sh[CMD_BITS-1] ? (us_el < EW'(1)) : (us_el < EW'(3));
                if (cell_end && tx_left == CLW'(1)) state_nxt = TX_STOP;
            end
            TX_STOP: begin
                data_oe = 1'b1;
                if (us_tick) state_nxt = (rx_len == '0) ? FINISH : RX_WAIT;
            end
            RX_WAIT: begin
                if (fall) begin
                    state_nxt = RX_SAMPLE;
                end else if (to_expired) begin
                    state_nxt = FINISH;
                    set_to    = 1'b1;
                end
            end
            RX_SAMPLE: begin
                if (sample_now) state_nxt = RX_HIGH;
            end
            RX_HIGH: begin
                if (sync) begin
                    state_nxt = (rx_cnt == rx_len) ? FINISH : RX_WAIT;
                end else if (to_expired) begin
                    state_nxt = FINISH;
                    set_to    = 1'b1;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            // Line idles high; presetting the synchroniser avoids a false edge.
            sync_meta <= 1'b1;
            sync      <= 1'b1;
            sync_prev <= 1'b1;
            us_cnt    <= '0;
            us_el     <= '0;
            tx_sh     <= '0;
            tx_left   <= '0;
            rx_len    <= '0;
            rx_cnt    <= '0;
            rx_sh     <= '0;
            timeout_r <= 1'b0;
            rsp       <= '0;
        end else begin
            sync_meta <= data_in;
            sync      <= sync_meta;
            sync_prev <= sync;

            // Timebase restarts on every state entry; TX cells wrap it per bit.
            if (state_nxt != state || state == IDLE) begin
                us_cnt <= '0;
                us_el  <= '0;
            end else if (us_tick) begin
                us_cnt <= '0;
                us_el  <= cell_end ? '0 : us_el + 1'b1;
            end else begin
                us_cnt <= us_cnt + 1'b1;
            end

            if (state == IDLE && start) begin
                tx_sh   <= tx_init;
                tx_left <= cmd_len_c;
                rx_len  <= rsp_len_c;
                rx_cnt  <= '0;
                rx_sh   <= '0;
            end

            if (cell_end) begin
                tx_sh   <= tx_sh << 1;
                tx_left <= tx_left - 1'b1;
            end

            if (state == RX_SAMPLE && sample_now) begin
                rx_sh <= {rx_sh[RSP_BITS-2:0], sync};
                if (rx_cnt != RLW'(RSP_BITS)) rx_cnt <= rx_cnt + 1'b1;
            end

            if (state != FINISH && state_nxt == FINISH) begin
                timeout_r <= set_to;
                if (!set_to) rsp <= rx_sh;
            end
        end
    end

    assign busy    = (state != IDLE) && (state != FINISH);
    assign done    = (state == FINISH);
    assign timeout = done & timeout_r;

endmodule

// File: tb/tb_joybus_poll_master.sv
// Scoreboard bench for joybus_poll_master: a 100-cycle/us instance with a
// controller line model, and a 4-cycle/us instance for short-cell checks.
module tb_joybus_poll_master;
    logic clk100mhz = 1'b0;
    always #5 clk100mhz = ~clk100mhz;

    logic reset = 1'b1;
    int   cyc   = 0;
    always @(posedge clk100mhz) cyc <= cyc + 1;

    logic        start_a = 1'b0;
    logic [23:0] cmd_a = '0;
    logic [4:0]  cmd_len_a = '0;
    logic [6:0]  rsp_len_a = '0;
    logic        data_in_a, data_oe_a, busy_a, done_a, timeout_a;
    logic [63:0] rsp_a;
    logic        ctrl_low = 1'b0;
    assign data_in_a = ~(data_oe_a | ctrl_low);

    logic        start_b = 1'b0;
    logic [7:0]  cmd_b = '0;
    logic [3:0]  cmd_len_b = '0;
    logic [3:0]  rsp_len_b = '0;
    logic        data_in_b, data_oe_b, busy_b, done_b, timeout_b;
    logic [7:0]  rsp_b;
    assign data_in_b = ~data_oe_b;

    joybus_poll_master dut_a (
        .clk100mhz(clk100mhz), .reset(reset), .start(start_a), .cmd(cmd_a),
        .cmd_len(cmd_len_a), .rsp_len(rsp_len_a), .data_in(data_in_a),
        .data_oe(data_oe_a), .busy(busy_a), .done(done_a), .timeout(timeout_a), .rsp(rsp_a)
    );

    joybus_poll_master #(.CLK_PER_US(4), .CMD_BITS(8), .RSP_BITS(8), .TIMEOUT_US(10)) dut_b (
        .clk100mhz(clk100mhz), .reset(reset), .start(start_b), .cmd(cmd_b),
        .cmd_len(cmd_len_b), .rsp_len(rsp_len_b), .data_in(data_in_b),
        .data_oe(data_oe_b), .busy(busy_b), .done(done_b), .timeout(timeout_b), .rsp(rsp_b)
    );

    logic        oe_v[2], done_v[2], busy_v[2], to_v[2];
    logic [63:0] rsp_v[2];
    assign oe_v[0] = data_oe_a;  assign oe_v[1] = data_oe_b;
    assign done_v[0] = done_a;   assign done_v[1] = done_b;
    assign busy_v[0] = busy_a;   assign busy_v[1] = busy_b;
    assign to_v[0] = timeout_a;  assign to_v[1] = timeout_b;
    assign rsp_v[0] = rsp_a;     assign rsp_v[1] = {56'd0, rsp_b};

    typedef struct { int st; int len; } pul_t;
    typedef struct { int cy; logic to; logic [63:0] rsp; } res_t;

    pul_t pq[2][$];
    res_t sbq[2][$];
    bit   pmon_en[2];
    bit   prev_oe[2];
    int   run_st[2];
    int   checks = 0;
    int   errors = 0;
    pul_t mp;
    res_t mr;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: measures every low pulse on data_oe and every done pulse.
    always @(negedge clk100mhz) begin
        for (int d = 0; d < 2; d++) begin
            if (oe_v[d] === 1'b1 && !prev_oe[d]) run_st[d] = cyc;
            if (oe_v[d] === 1'b0 && prev_oe[d] && pmon_en[d]) begin
                if (pq[d].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pulse%0d: unexpected pulse start %0d len %0d", d, run_st[d], cyc - run_st[d]);
                end else begin
                    mp = pq[d].pop_front();
                    check($sformatf("pulse%0d_start", d), 64'(run_st[d]), 64'(mp.st));
                    check($sformatf("pulse%0d_len", d), 64'(cyc - run_st[d]), 64'(mp.len));
                end
            end
            prev_oe[d] = (oe_v[d] === 1'b1);
            if (done_v[d] === 1'b1) begin
                if (sbq[d].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done%0d: unexpected done at cycle %0d", d, cyc);
                end else begin
                    mr = sbq[d].pop_front();
                    if (mr.cy >= 0) check($sformatf("done%0d_cycle", d), 64'(cyc), 64'(mr.cy));
                    check($sformatf("done%0d_timeout", d), 64'(to_v[d]), 64'(mr.to));
                    check($sformatf("done%0d_rsp", d), rsp_v[d], mr.rsp);
                    check($sformatf("done%0d_busy", d), 64'(busy_v[d]), 64'd0);
                end
            end
        end
    end

    task automatic go(input int d, input logic [23:0] c, input int cl, input int rl, output int s);
        @(negedge clk100mhz);
        if (d == 0) begin
            cmd_a = c; cmd_len_a = 5'(cl); rsp_len_a = 7'(rl); start_a = 1'b1;
        end else begin
            cmd_b = c[7:0]; cmd_len_b = 4'(cl); rsp_len_b = 4'(rl); start_b = 1'b1;
        end
        s = cyc + 1;
        @(negedge clk100mhz);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic push_tx(input int d, input int s, input logic [23:0] c, input int cl, input int us);
        pul_t p;
        for (int i = cl - 1; i >= 0; i--) begin
            p.st  = s + 4 * us * (cl - 1 - i);
            p.len = c[i] ? us : 3 * us;
            pq[d].push_back(p);
        end
        p.st  = s + 4 * us * cl;
        p.len = us;
        pq[d].push_back(p);
    endtask

    task automatic push_res(input int d, input int cy, input logic to, input logic [63:0] r);
        res_t e;
        e.cy = cy; e.to = to; e.rsp = r;
        sbq[d].push_back(e);
    endtask

    task automatic wait_idle(input int d, input int budget);
        int n = 0;
        while (busy_v[d] !== 1'b0 && n < budget) begin
            @(negedge clk100mhz);
            n++;
        end
        if (busy_v[d] !== 1'b0) begin
            checks++; errors++;
            $display("FAIL wait%0d: still busy after %0d cycles", d, budget);
        end
    endtask

    // Controller reply at 100 cycles/us: 0 = low 3us, 1 = low 1us.
    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ctrl_low = 1'b1;
            repeat (v[i] ? 100 : 300) @(negedge clk100mhz);
            ctrl_low = 1'b0;
            repeat (v[i] ? 300 : 100) @(negedge clk100mhz);
        end
    endtask

    initial begin
        int s, r, k;
        pmon_en[0] = 1'b1;
        pmon_en[1] = 1'b1;
        repeat (3) @(negedge clk100mhz);
        check("rst_oe", 64'(data_oe_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_timeout", 64'(timeout_a), 64'd0);
        check("rst_rsp", rsp_a, 64'd0);
        reset = 1'b0;

        // Full 24-bit command, no response expected.
        go(0, 24'h400300, 24, 0, s);
        push_tx(0, s, 24'h400300, 24, 100);
        push_res(0, s + 9700, 1'b0, 64'd0);
        wait_idle(0, 12000);

        // Reply 0x090000 starting 5us after release.
        go(0, 24'h0, 8, 24, s);
        push_tx(0, s, 24'h0, 8, 100);
        push_res(0, -1, 1'b0, 64'h090000);
        r = s + 3300;
        while (cyc < r + 499) @(negedge clk100mhz);
        send_bits(64'h090000, 24);
        wait_idle(0, 25000);

        // No reply: timeout 20000 cycles after release, rsp kept.
        go(0, 24'h40, 8, 64, s);
        push_tx(0, s, 24'h40, 8, 100);
        push_res(0, s + 3300 + 20000, 1'b1, 64'h090000);
        wait_idle(0, 25000);

        // Line stuck low after the 10th bit.
        go(0, 24'h0, 8, 24, s);
        push_tx(0, s, 24'h0, 8, 100);
        r = s + 3300;
        while (cyc < r + 499) @(negedge clk100mhz);
        send_bits(64'h024, 10);
        ctrl_low = 1'b1;
        k = cyc;
        push_res(0, k + 20203, 1'b1, 64'h090000);
        wait_idle(0, 25000);
        ctrl_low = 1'b0;

        // Reset in the middle of TX, then a fresh transaction.
        pmon_en[0] = 1'b0;
        go(0, 24'h400300, 24, 0, s);
        while (cyc < s + 4999) @(negedge clk100mhz);
        reset = 1'b1;
        @(negedge clk100mhz);
        check("midrst_oe", 64'(data_oe_a), 64'd0);
        check("midrst_busy", 64'(busy_a), 64'd0);
        check("midrst_done", 64'(done_a), 64'd0);
        check("midrst_rsp", rsp_a, 64'd0);
        reset = 1'b0;
        while (cyc < s + 5008) @(negedge clk100mhz);
        pmon_en[0] = 1'b1;
        go(0, 24'hA, 4, 0, s);
        push_tx(0, s, 24'hA, 4, 100);
        push_res(0, s + 1700, 1'b0, 64'd0);
        wait_idle(0, 3000);

        // 4 cycles/us: single 1 bit, start pulses during busy and done ignored.
        go(1, 24'h1, 1, 0, s);
        push_tx(1, s, 24'h1, 1, 4);
        push_res(1, s + 20, 1'b0, 64'd0);
        while (cyc < s + 4) @(negedge clk100mhz);
        start_b = 1'b1;
        @(negedge clk100mhz);
        start_b = 1'b0;
        while (cyc < s + 20) @(negedge clk100mhz);
        start_b = 1'b1;
        @(negedge clk100mhz);
        start_b = 1'b0;
        repeat (40) @(negedge clk100mhz);
        check("b_busy_after", 64'(busy_b), 64'd0);

        // Zero-length command goes straight to the stop bit.
        go(1, 24'h0, 0, 0, s);
        push_tx(1, s, 24'h0, 0, 4);
        push_res(1, s + 4, 1'b0, 64'd0);
        wait_idle(1, 100);

        // Over-long cmd_len clamps to the full 8-bit command.
        go(1, 24'hA5, 15, 0, s);
        push_tx(1, s, 24'hA5, 8, 4);
        push_res(1, s + 8 * 16 + 4, 1'b0, 64'd0);
        wait_idle(1, 300);

        repeat (5) @(negedge clk100mhz);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("res%0d_left", d), 64'(sbq[d].size()), 64'd0);
            check($sformatf("pul%0d_left", d), 64'(pq[d].size()), 64'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/joybus_poll_master.md
Name: joybus_poll_master

Overview:
Parametrised Joybus (GameCube controller) bus master. It serialises a command of variable length onto the open-drain controller data line, sends the stop bit, then captures a variable-length response from the controller, with a timeout. It sits between the controller-polling sequencer and the bidirectional pad: data_oe drives the pad low, and data_in is the raw pad input.

Parameters:
CLK_PER_US, 100, clk100mhz cycles per microsecond (must be ≥4)
CMD_BITS, 24, max command length in bits
RSP_BITS, 64, max response length in bits
TIMEOUT_US, 200, max µs to wait for any response falling edge or low-to-high return

Ports:
clk100mhz  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  request transaction; accepted only in IDLE
cmd  in  CMD_BITS  command, right-aligned; cmd[cmd_len-1] sent first
cmd_len  in  $clog2(CMD_BITS+1)  number of command bits, sampled at start
rsp_len  in  $clog2(RSP_BITS+1)  number of response bits expected, sampled at start
data_in  in  1  raw pad input, asynchronous
data_oe  out  1  1 = pull line low, 0 = release (high-Z)
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
timeout  out  1  valid with done; 1 = response not completed
rsp  out  RSP_BITS  response, right-aligned, MSB-first shift; upper bits zero

Behaviour:
- Reset (edge-sampled while high): data_oe=0, busy=0, done=0, timeout=0, rsp=0, state=IDLE. Reset mid-transaction aborts at the next edge and produces no done pulse.
- Microsecond timebase: counter 0..CLK_PER_US-1, restarted on each state entry. 1 µs = exactly CLK_PER_US cycles.
- States: IDLE → TX_BIT → TX_STOP → RX_WAIT → RX_SAMPLE → RX_HIGH → (RX_WAIT | FINISH) → IDLE.
- IDLE:
  - start=1 at edge N latches cmd, cmd_len and rsp_len.
  - busy=1 and data_oe=1 from cycle N+1.
  - start is ignored while busy=1, including the done cycle.
- TX_BIT: each cell is 4 µs.
  - Bit 0: low 3 µs, released 1 µs.
  - Bit 1: low 1 µs, released 3 µs.
  - Bits are sent MSB-first from cmd[cmd_len-1].
  - cmd_len=0: skip directly to TX_STOP.
  - data_in is ignored during TX.
- TX_STOP: low 1 µs, then release.
  - rsp_len=0: go to FINISH with timeout=0.
  - Otherwise: go to RX_WAIT.
- Receive path:
  - data_in passes through a 2-flop synchroniser (2-cycle latency).
  - A falling edge is sync=0 while the previous sync=1.
- RX_WAIT:
  - Falling edge: go to RX_SAMPLE.
  - TIMEOUT_US×CLK_PER_US cycles without an edge: FINISH with timeout=1.
- RX_SAMPLE: exactly 2×CLK_PER_US cycles after the edge, shift in the inverted-low sample (sync=1 → bit 1, sync=0 → bit 0), then go to RX_HIGH.
- RX_HIGH: wait for sync=1.
  - Same timeout rule as RX_WAIT applies.
  - Then, if bits received == rsp_len: FINISH. Otherwise: RX_WAIT.
  - The controller's trailing stop bit is not required.
- FINISH: one cycle.
  - done=1 and busy=0 in the same cycle.
  - On success: rsp is updated with the assembled bits, zero-extended.
  - On timeout: rsp keeps its previous value.
  - data_oe is 0 throughout RX and FINISH.
- Width rules:
  - cmd_len > CMD_BITS clamps to CMD_BITS.
  - rsp_len > RSP_BITS clamps to RSP_BITS.
  - The bit counter never wraps.

Test Plan:
1. cmd=0x400300, cmd_len=24, rsp_len=0, start at cycle 0:
   - data_oe high/low pattern 24×400 cycles; first cell low 300 / high 100; bit 22 low 100 / high 300.
   - Stop bit low cycles 9601–9700.
   - done=1, timeout=0 at cycle 9701.
2. cmd=0x00, len 8, rsp_len=24; controller model replies 0x090000 at 4 µs/bit, starting 5 µs after release → done, timeout=0, rsp=0x000000000090000 (right-aligned).
3. Poll command with no model reply → done and timeout=1 exactly TIMEOUT_US×100 cycles after stop-bit release; rsp unchanged from the previous value.
4. Model holds the line low after the 10th response bit → timeout=1 after 20000 cycles; busy=0 the same cycle.
5. reset asserted at cycle 5000 during TX → data_oe=0 and busy=0 at cycle 5001; no done; a new start at cycle 5010 is accepted normally.
6. CLK_PER_US=4, cmd=0b1, cmd_len=1 → low 4 cycles, high 12 cycles, stop low 4 cycles; start pulsed during busy is ignored (single done).
